// File: rtl/wb_arbiter.sv
// Write-back arbiter: two producers, one holding slot each, one register-file write port.
// Define WB_RR_ARB_EN for round-robin on contention; otherwise producer A has fixed priority.
module wb_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [1:0]        a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_nowrite,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_rd,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_nowrite,
    output logic              reg0_en,
    output logic              reg1_en,
    output logic              reg2_en,
    output logic              reg3_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              wb_src
);

    logic              occ_a_q, occ_a_d;
    logic [1:0]        rd_a_q, rd_a_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic              nw_a_q, nw_a_d;

    logic              occ_b_q, occ_b_d;
    logic [1:0]        rd_b_q, rd_b_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              nw_b_q, nw_b_d;

    logic [3:0]        en_q, en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wb_src_q, wb_src_d;

    logic              a_wins;
    logic              grant_a, grant_b;
    logic [1:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              sel_nw;

`ifdef WB_RR_ARB_EN
    // Last contested winner: 0 = A, 1 = B. Reset to B so A takes the first contest.
    logic rr_q, rr_d;
    assign a_wins = rr_q;
`else
    assign a_wins = 1'b1;
`endif

    // Grant depends only on slot occupancy, never on the valid inputs.
    assign grant_a = occ_a_q & (~occ_b_q | a_wins);
    assign grant_b = occ_b_q & ~grant_a;

    assign a_ready = rst_n & (~occ_a_q | grant_a);
    assign b_ready = rst_n & (~occ_b_q | grant_b);

    assign sel_rd   = grant_b ? rd_b_q   : rd_a_q;
    assign sel_data = grant_b ? data_b_q : data_a_q;
    assign sel_nw   = grant_b ? nw_b_q   : nw_a_q;

    always_comb begin
        occ_a_d   = occ_a_q;
        rd_a_d    = rd_a_q;
        data_a_d  = data_a_q;
        nw_a_d    = nw_a_q;
        occ_b_d   = occ_b_q;
        rd_b_d    = rd_b_q;
        data_b_d  = data_b_q;
        nw_b_d    = nw_b_q;
        en_d      = 4'b0000;
        wr_data_d = wr_data_q;
        wb_src_d  = wb_src_q;

        if (grant_a || grant_b) begin
            wr_data_d = sel_data;
            wb_src_d  = grant_b;
            if (!sel_nw) begin
                en_d = 4'b0001 << sel_rd;
            end
        end

        // A new request on a slot being granted this edge refills it with no bubble.
        if (grant_a) begin
            occ_a_d = 1'b0;
        end
        if (a_valid && a_ready) begin
            occ_a_d  = 1'b1;
            rd_a_d   = a_rd;
            data_a_d = a_data;
            nw_a_d   = a_nowrite;
        end

        if (grant_b) begin
            occ_b_d = 1'b0;
        end
        if (b_valid && b_ready) begin
            occ_b_d  = 1'b1;
            rd_b_d   = b_rd;
            data_b_d = b_data;
            nw_b_d   = b_nowrite;
        end
    end

`ifdef WB_RR_ARB_EN
    always_comb begin
        rr_d = rr_q;
        if (occ_a_q && occ_b_q) begin
            rr_d = grant_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_a_q   <= 1'b0;
            rd_a_q    <= 2'd0;
            data_a_q  <= '0;
            nw_a_q    <= 1'b0;
            occ_b_q   <= 1'b0;
            rd_b_q    <= 2'd0;
            data_b_q  <= '0;
            nw_b_q    <= 1'b0;
            en_q      <= 4'b0000;
            wr_data_q <= '0;
            wb_src_q  <= 1'b0;
        end else begin
            occ_a_q   <= occ_a_d;
            rd_a_q    <= rd_a_d;
            data_a_q  <= data_a_d;
            nw_a_q    <= nw_a_d;
            occ_b_q   <= occ_b_d;
            rd_b_q    <= rd_b_d;
            data_b_q  <= data_b_d;
            nw_b_q    <= nw_b_d;
            en_q      <= en_d;
            wr_data_q <= wr_data_d;
            wb_src_q  <= wb_src_d;
        end
    end

    assign reg0_en = en_q[0];
    assign reg1_en = en_q[1];
    assign reg2_en = en_q[2];
    assign reg3_en = en_q[3];
    assign wr_data = wr_data_q;
    assign wb_src  = wb_src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: reset, single write, nowrite, contention,
// sustained streaming (fixed priority or WB_RR_ARB_EN round-robin), back-to-back.
module tb_wb_arbiter;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_n;
    logic              a_valid, a_ready, a_nowrite;
    logic [1:0]        a_rd;
    logic [DATA_W-1:0] a_data;
    logic              b_valid, b_ready, b_nowrite;
    logic [1:0]        b_rd;
    logic [DATA_W-1:0] b_data;
    logic              reg0_en, reg1_en, reg2_en, reg3_en;
    logic [DATA_W-1:0] wr_data;
    logic              wb_src;

    int n_checks;
    int n_errors;

    wb_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_nowrite (a_nowrite),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .b_nowrite (b_nowrite),
        .reg0_en   (reg0_en),
        .reg1_en   (reg1_en),
        .reg2_en   (reg2_en),
        .reg3_en   (reg3_en),
        .wr_data   (wr_data),
        .wb_src    (wb_src)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] en_vec();
        return {reg3_en, reg2_en, reg1_en, reg0_en};
    endfunction

    task automatic idle_inputs();
        a_valid = 1'b0; a_rd = 2'd0; a_data = '0; a_nowrite = 1'b0;
        b_valid = 1'b0; b_rd = 2'd0; b_data = '0; b_nowrite = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] en, input logic [7:0] d,
                             input logic src);
        check({tag, ".en"}, {28'd0, en_vec()}, {28'd0, en});
        check({tag, ".data"}, {24'd0, wr_data}, {24'd0, d});
        check({tag, ".src"}, {31'd0, wb_src}, {31'd0, src});
    endtask

    // Expected grant order for the streaming test (src per output cycle, data per output cycle).
    logic [7:0] exp_src;
    logic [7:0] exp_dat [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst_n = 1'b0;

`ifdef WB_RR_ARB_EN
        // Pointer is left at "A won last" by the contention test, so B takes the first contest.
        exp_src = 8'b0101_0101;
        exp_dat[0] = 8'hB0; exp_dat[1] = 8'hA0; exp_dat[2] = 8'hB1; exp_dat[3] = 8'hA1;
        exp_dat[4] = 8'hB2; exp_dat[5] = 8'hA2; exp_dat[6] = 8'hB3; exp_dat[7] = 8'hA3;
`else
        exp_src = 8'b1111_0000;
        exp_dat[0] = 8'hA0; exp_dat[1] = 8'hA1; exp_dat[2] = 8'hA2; exp_dat[3] = 8'hA3;
        exp_dat[4] = 8'hB0; exp_dat[5] = 8'hB1; exp_dat[6] = 8'hB2; exp_dat[7] = 8'hB3;
`endif

        // Reset state
        step(); step();
        check_out("rst", 4'b0000, 8'h00, 1'b0);
        check("rst.a_ready", {31'd0, a_ready}, 32'd0);
        check("rst.b_ready", {31'd0, b_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel.a_ready", {31'd0, a_ready}, 32'd1);
        check("rel.b_ready", {31'd0, b_ready}, 32'd1);

        // Single write: A rd=2 data=0x5A
        a_valid = 1'b1; a_rd = 2'd2; a_data = 8'h5A;
        step();
        idle_inputs();
        check("single.e0", {28'd0, en_vec()}, 32'd0);
        step();
        check_out("single.e1", 4'b0100, 8'h5A, 1'b0);
        step();
        check_out("single.e2", 4'b0000, 8'h5A, 1'b0);

        // nowrite from B
        b_valid = 1'b1; b_rd = 2'd1; b_data = 8'h33; b_nowrite = 1'b1;
        #1;
        check("nw.b_ready", {31'd0, b_ready}, 32'd1);
        step();
        idle_inputs();
        step();
        check_out("nw", 4'b0000, 8'h33, 1'b1);

        // Contention on the same rd
        a_valid = 1'b1; a_rd = 2'd3; a_data = 8'h11;
        b_valid = 1'b1; b_rd = 2'd3; b_data = 8'h22;
        step();
        idle_inputs();
        check("cont.b_ready0", {31'd0, b_ready}, 32'd0);
        check("cont.a_ready0", {31'd0, a_ready}, 32'd1);
        step();
        check_out("cont.g1", 4'b1000, 8'h11, 1'b0);
        step();
        check_out("cont.g2", 4'b1000, 8'h22, 1'b1);
        step();
        check("cont.idle", {28'd0, en_vec()}, 32'd0);

        // Sustained streaming: A 4 requests (rd1, A0..A3), B 4 requests (rd0, B0..B3)
        begin
            int a_cnt = 0;
            int b_cnt = 0;
            for (int cyc = 0; cyc < 9; cyc++) begin
                logic hs_a, hs_b;
                a_valid = (a_cnt < 4); a_rd = 2'd1; a_data = 8'hA0 + 8'(a_cnt);
                b_valid = (b_cnt < 4); b_rd = 2'd0; b_data = 8'hB0 + 8'(b_cnt);
                #1;
                hs_a = a_valid & a_ready;
                hs_b = b_valid & b_ready;
                step();
                if (hs_a) a_cnt++;
                if (hs_b) b_cnt++;
                if (cyc >= 1) begin
                    check_out($sformatf("stream.%0d", cyc - 1),
                              exp_src[cyc - 1] ? 4'b0001 : 4'b0010,
                              exp_dat[cyc - 1], exp_src[cyc - 1]);
                end
            end
            idle_inputs();
            step();
            check("stream.idle", {28'd0, en_vec()}, 32'd0);
        end

        // Back-to-back from A alone
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                a_valid = 1'b1; a_rd = 2'(i); a_data = 8'(i + 1);
                #1;
                check($sformatf("b2b.ready%0d", i), {31'd0, a_ready}, 32'd1);
            end else begin
                idle_inputs();
            end
            step();
            if (i >= 1) begin
                check_out($sformatf("b2b.%0d", i - 1), 4'b0001 << (i - 1), 8'(i), 1'b0);
            end
        end
        step();
        check("b2b.idle", {28'd0, en_vec()}, 32'd0);

        // Reset mid-cycle with an enable high and slot A occupied
        a_valid = 1'b1; a_rd = 2'd2; a_data = 8'h77;
        step();
        a_rd = 2'd3; a_data = 8'h66;
        step();
        idle_inputs();
        check_out("mrst.pre", 4'b0100, 8'h77, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("mrst", 4'b0000, 8'h00, 1'b0);
        check("mrst.a_ready", {31'd0, a_ready}, 32'd0);
        check("mrst.b_ready", {31'd0, b_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("mrst.rel_a_ready", {31'd0, a_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mrst.nowr%0d", i), {28'd0, en_vec()}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the sCPU's 4-entry register file. Accepts register write requests from two producers (A: ALU result path, B: load/memory return path) over valid/ready handshakes, buffers one request per producer, and grants the single register-file write port to one buffered request per cycle. It drives the one-hot `reg0_en`..`reg3_en` write enables and `wr_data` directly into the register file. A request tagged `nowrite` (branch-not-equal class) is consumed without asserting any enable.

## Interface

- Parameter `DATA_W`, default 8: width of write data.

- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst_n`  in  1  : asynchronous, active-low reset.
- `a_valid`  in  1  : producer A request valid.
- `a_ready`  out  1  : producer A request accepted when `a_valid & a_ready` at a rising edge.
- `a_rd`  in  2  : producer A destination register index.
- `a_data`  in  DATA_W  : producer A write data.
- `a_nowrite`  in  1  : producer A request consumes a slot but writes nothing.
- `b_valid`, `b_ready`, `b_rd`, `b_data`, `b_nowrite`: same as the A ports, for producer B.
- `reg0_en`..`reg3_en`  out  1 each  : registered one-hot register-file write enables.
- `wr_data`  out  DATA_W  : registered write data. Valid whenever any `regN_en` is high.
- `wb_src`  out  1  : registered source of the last grant (0 = A, 1 = B).

## Operation

- Each producer owns a 1-entry holding slot {occ, rd, data, nowrite}.
- Grant logic is combinational from slot occupancy only; it never depends on `*_valid`.
  - Only one slot occupied: that slot is granted.
  - Both slots occupied: A wins by default (see Configuration).
- `x_ready` = `~occ_x | grant_x`. It is forced to 0 while `rst_n` is low.
- At each rising edge:
  - A granted slot is emptied, and its contents are loaded into the output registers.
  - If `nowrite = 0`, `reg[rd]_en` is set to 1 and all other enables to 0.
  - If `nowrite = 1`, all four enables are 0. `wr_data` and `wb_src` are still updated.
  - With no grant, all enables go to 0. `wr_data` and `wb_src` hold their values.
  - An accepted request loads the slot (`occ = 1`). If the same slot was granted on the same edge, the new request replaces it with no bubble.
- Both producers targeting the same `rd`: the writes are performed in grant order, in separate cycles. The later grant overwrites the earlier one in the register file.
- No more than one `regN_en` is high in any cycle.

## Timing

- Reset (`rst_n` low, asynchronous):
  - Slots are emptied.
  - `reg0_en`..`reg3_en` = 0, `wr_data` = 0, `wb_src` = 0.
  - `a_ready` = `b_ready` = 0.
  - The round-robin pointer is set so that A wins first.
- After reset release: `a_ready` = `b_ready` = 1 in the first cycle.
- Latency: a request accepted at edge E0 is granted at edge E0+1 if uncontested. The enable is high during the cycle following E0+1, which is 2 edges from handshake to visible enable.
- Throughput:
  - One request per cycle per producer when uncontested.
  - Aggregate write-port throughput is one write per cycle.
- Contention: the loser's slot stays occupied and its `ready` is 0 until it is granted. Its `x_rd`/`x_data`/`x_nowrite` inputs are ignored while the slot is full.
- Reset asserted mid-operation: buffered requests are discarded and any pending enable is cleared immediately, not at the next edge.

## Configuration

- `WB_RR_ARB_EN` defined:
  - Round-robin arbitration on contention. A 1-bit pointer records the last winner, and the other producer wins the next contested cycle.
  - The pointer updates only on contested grants.
  - Reset state: A wins the first contest.
- `WB_RR_ARB_EN` undefined: fixed priority, A always wins contention, and B can starve while A sustains back-to-back requests.

## Test plan

- Reset: assert `rst_n` = 0 mid-cycle with slot A occupied -> all enables 0, `wr_data` = 0, and `a_ready` = `b_ready` = 0 immediately. After release, `a_ready` = 1 and no write appears from the discarded request.
- Single write: A sends rd = 2, data = 0x5A at edge 0 -> `reg2_en` = 1 and `wr_data` = 0x5A for exactly one cycle after edge 1, with `wb_src` = 0.
- `nowrite`: B sends rd = 1, data = 0x33, nowrite = 1 -> `b_ready` handshake completes, all enables stay 0, and `wr_data` = 0x33, `wb_src` = 1.
- Contention, same rd: A (rd = 3, 0x11) and B (rd = 3, 0x22) in the same cycle -> `reg3_en` with 0x11 (`wb_src` = 0), then `reg3_en` with 0x22 (`wb_src` = 1), and `b_ready` = 0 during the first grant.
- Sustained A with B pending:
  - With `WB_RR_ARB_EN`, grants alternate A, B, A, B…
  - Without it, B is never granted until A deasserts `a_valid`, then B writes in the next cycle.
- Back-to-back: A streams 4 requests (rd 0..3, data 0x01..0x04) with `b_valid` = 0 -> `reg0_en`..`reg3_en` assert on 4 consecutive cycles with matching data, and `a_ready` stays 1 throughout.
